prm_edge_scan: RTL and testbench

PRM_EDGE_SCAN -- requirements
Module: prm_edge_scan

---
 rtl/prm_scan_pkg.sv | 15 +
 rtl/prm_scan_fifo.sv | 55 +++++
 rtl/prm_edge_scan.sv | 196 +++++++++++++++++++
 tb/tb_prm_edge_scan.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/prm_scan_pkg.sv
// Shared widths, FIFO depth and scan state encoding for the edge-scan block.
package prm_scan_pkg;

  localparam int PRM_CODE_W     = 15;
  localparam int PRM_WORD_W     = 32;
  localparam int PRM_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/prm_scan_fifo.sv
// Two-entry valid/ready FIFO holding {last, data} result words.
// A push is accepted while full if a pop happens in the same cycle.
module prm_scan_fifo
  import prm_scan_pkg::*;
#(
  parameter int WORD_W = PRM_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last
);

  logic [WORD_W:0] mem [PRM_FIFO_DEPTH];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      cnt;
  logic            push;
  logic            pop;

  assign out_valid = (cnt != 2'd0);
  assign in_ready  = (cnt < 2'(PRM_FIFO_DEPTH)) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr][WORD_W-1:0] : '0;
  assign out_last  = out_valid ? mem[rd_ptr][WORD_W] : 1'b0;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PRM_FIFO_DEPTH; k++) mem[k] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_last, in_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/prm_edge_scan.sv
// Sweeps a range of edge query codes through the obstacle checker and packs
// the returned mask bits into words, LSB first, behind a credited 2-word FIFO.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start
// S_ISSUE | driving one query per cycle, stalls at a word boundary w/o credit
// S_DRAIN | all queries issued, waiting for the last word to be popped
// S_DONE  | one-cycle done pulse, then back to idle
module prm_edge_scan
  import prm_scan_pkg::*;
#(
  parameter int CODE_W  = PRM_CODE_W,
  parameter int WORD_W  = PRM_WORD_W,
  parameter int CHK_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CODE_W-1:0] base_code,
  input  logic [15:0]       count,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] q_code,
  output logic              q_valid,
  input  logic              q_mask,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_data,
  output logic              res_last,
  output logic [15:0]       blk_cnt
);

  localparam int BIT_W = $clog2(WORD_W);

  scan_state_e       state, state_nxt;
  logic [CODE_W-1:0] base_r;
  logic [15:0]       count_r;
  logic [15:0]       last_idx;
  logic [15:0]       idx;
  logic [1:0]        credits;
  logic              accept;
  logic              at_bound;
  logic              stall;
  logic              consume;
  logic              pop;
  logic              smp_v;
  logic [15:0]       smp_idx;
  logic [BIT_W-1:0]  smp_bit;
  logic [WORD_W-1:0] asm_r, asm_nxt;
  logic              word_done;
  logic              push;
  logic              push_last;
  logic              fifo_in_ready;

  assign accept   = (state == S_IDLE) && start;
  assign last_idx = count_r - 16'd1;
  assign at_bound = (idx[BIT_W-1:0] == '0);
  assign pop      = res_valid && res_ready;
  // A pop this cycle frees a slot, so it may release a boundary stall at once.
  assign stall    = at_bound && (credits == 2'd0) && !pop;
  assign consume  = q_valid && at_bound;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    q_valid   = 1'b0;
    q_code    = '0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = (count == 16'd0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        busy    = 1'b1;
        q_code  = base_r + CODE_W'(idx);
        q_valid = !stall;
        if (q_valid && (idx == last_idx)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pop && res_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Scan parameters and query index.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r  <= '0;
      count_r <= '0;
      idx     <= '0;
    end else if (accept) begin
      base_r  <= base_code;
      count_r <= count;
      idx     <= '0;
    end else if (q_valid) begin
      idx <= idx + 16'd1;
    end
  end

  // Word credits: taken when a word's first query issues, returned on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= 2'(PRM_FIFO_DEPTH);
    end else begin
      case ({consume, pop})
        2'b10:   credits <= credits - 2'd1;
        2'b01:   credits <= credits + 2'd1;
        default: credits <= credits;
      endcase
    end
  end

  // Checker latency pipe: q_mask belongs to the query issued CHK_LAT cycles ago.
  generate
    if (CHK_LAT == 0) begin : g_nopipe
      assign smp_v   = q_valid;
      assign smp_idx = idx;
    end else begin : g_pipe
      logic [CHK_LAT-1:0] pv;
      logic [15:0]        pidx [CHK_LAT];

      // Shift query valid/index along with the checker's latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          pv <= '0;
          for (int k = 0; k < CHK_LAT; k++) pidx[k] <= '0;
        end else begin
          pv[0]   <= q_valid;
          pidx[0] <= idx;
          for (int k = 1; k < CHK_LAT; k++) begin
            pv[k]   <= pv[k-1];
            pidx[k] <= pidx[k-1];
          end
        end
      end

      assign smp_v   = pv[CHK_LAT-1];
      assign smp_idx = pidx[CHK_LAT-1];
    end
  endgenerate

  assign smp_bit   = smp_idx[BIT_W-1:0];
  assign push_last = (smp_idx == last_idx);
  assign word_done = (smp_bit == BIT_W'(WORD_W - 1)) || push_last;
  assign push      = smp_v && word_done && fifo_in_ready;

  // Word under assembly with the current result merged in; bit 0 starts fresh.
  always_comb begin
    asm_nxt = (smp_bit == '0) ? '0 : asm_r;
    if (q_mask) asm_nxt[smp_bit] = 1'b1;
  end

  // Assembly register, cleared whenever a word leaves for the FIFO.
  always_ff @(posedge clk) begin
    if (rst)        asm_r <= '0;
    else if (smp_v) asm_r <= word_done ? '0 : asm_nxt;
  end

  // Blocked-edge tally for the current or most recent scan.
  always_ff @(posedge clk) begin
    if (rst)                  blk_cnt <= '0;
    else if (accept)          blk_cnt <= '0;
    else if (smp_v && q_mask) blk_cnt <= blk_cnt + 16'd1;
  end

  prm_scan_fifo #(
    .WORD_W(WORD_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (push),
    .in_ready (fifo_in_ready),
    .in_data  (asm_nxt),
    .in_last  (push_last),
    .out_valid(res_valid),
    .out_ready(res_ready),
    .out_data (res_data),
    .out_last (res_last)
  );

endmodule

// File: tb/tb_prm_edge_scan.sv
// Scoreboard bench for prm_edge_scan with a one-cycle-latency checker model.
module tb_prm_edge_scan;
  import prm_scan_pkg::*;

  localparam int CODE_W = 15;
  localparam int WORD_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CODE_W-1:0] base_code;
  logic [15:0]       count;
  logic              busy, done, q_valid, q_mask, res_valid, res_ready, res_last;
  logic [CODE_W-1:0] q_code;
  logic [WORD_W-1:0] res_data;
  logic [15:0]       blk_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_pop_cyc = -100;
  int valid_seen   = 0;

  logic [WORD_W:0]   exp_words [$];
  logic [CODE_W-1:0] exp_codes [$];

  // Checker model state: up to two blocked codes.
  int                hit_n = 0;
  logic [CODE_W-1:0] hit_a = '0;
  logic [CODE_W-1:0] hit_b = '0;
  logic              pend  = 1'b0;

  prm_edge_scan #(.CODE_W(CODE_W), .WORD_W(WORD_W), .CHK_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .base_code(base_code), .count(count),
    .busy(busy), .done(done), .q_code(q_code), .q_valid(q_valid), .q_mask(q_mask),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Checker model: answer each query one cycle later.
  always @(negedge clk) begin
    pend = q_valid && ((hit_n > 0 && q_code == hit_a) || (hit_n > 1 && q_code == hit_b));
  end

  always @(posedge clk) begin
    #1 q_mask = pend;
  end

  // Monitor: compare every live query and every accepted word with the queues.
  always @(negedge clk) begin
    if (q_valid === 1'b1) begin
      if (exp_codes.size() == 0) begin
        checks++; failures++;
        $display("FAIL q_code_unexpected actual=%0h required=none", q_code);
      end else begin
        check("q_code", 64'(q_code), 64'(exp_codes.pop_front()));
      end
    end
    if (res_valid === 1'b1) valid_seen++;
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_words.size() == 0) begin
        checks++; failures++;
        $display("FAIL word_unexpected actual=%0h required=none", {res_last, res_data});
      end else begin
        check("res_word", 64'({res_last, res_data}), 64'(exp_words.pop_front()));
      end
      if (res_last) last_pop_cyc = cyc;
    end
  end

  task automatic do_start(input logic [CODE_W-1:0] b, input logic [15:0] n);
    @(posedge clk); #1;
    base_code = b; count = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_codes(input logic [CODE_W-1:0] b, input int n);
    for (int i = 0; i < n; i++) exp_codes.push_back(b + CODE_W'(i));
  endtask

  task automatic wait_done(input string name, input int budget, input bit chk_pop);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_done_timeout actual=none required=done within %0d", name, budget);
    end else begin
      if (chk_pop) check({name, "_done_after_pop"}, 64'(cyc - last_pop_cyc), 64'd1);
      @(negedge clk);
      check({name, "_done_width"}, 64'({done, busy}), 64'd0);
    end
  endtask

  task automatic check_drained(input string name);
    check({name, "_codes_left"}, 64'(exp_codes.size()), 64'd0);
    check({name, "_words_left"}, 64'(exp_words.size()), 64'd0);
  endtask

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; base_code = '0; count = '0; res_ready = 1'b1; q_mask = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({busy, done, q_valid, res_valid, res_last}), 64'd0);
    check("rst_q_code", 64'(q_code), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_blk_cnt", 64'(blk_cnt), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic scan: blocked codes 0x11, 0x13 -> bits 1 and 3.
    hit_n = 2; hit_a = 15'h0011; hit_b = 15'h0013;
    push_codes(15'h0010, 5);
    exp_words.push_back({1'b1, 32'h0000000A});
    do_start(15'h0010, 16'd5);
    wait_done("basic", 50, 1'b1);
    check("basic_blk_cnt", 64'(blk_cnt), 64'd2);
    check_drained("basic");

    // Code wrap: 7FFE, 7FFF, 0000, 0001; 0x0000 blocked -> bit 2.
    hit_n = 1; hit_a = 15'h0000;
    push_codes(15'h7FFE, 4);
    exp_words.push_back({1'b1, 32'h00000004});
    do_start(15'h7FFE, 16'd4);
    wait_done("wrap", 50, 1'b1);
    check("wrap_blk_cnt", 64'(blk_cnt), 64'd1);
    check_drained("wrap");

    // Empty scan: done only, no words, tally cleared.
    valid_seen = 0;
    do_start(15'h0055, 16'd0);
    wait_done("empty", 10, 1'b0);
    check("empty_valid_seen", 64'(valid_seen), 64'd0);
    check("empty_blk_cnt", 64'(blk_cnt), 64'd0);

    // Backpressure: 100 queries with no sink; issue stalls at index 64.
    res_ready = 1'b0;
    hit_n = 2; hit_a = 15'd3; hit_b = 15'd97;
    push_codes(15'h0000, 100);
    exp_words.push_back({1'b0, 32'h00000008});
    exp_words.push_back({1'b0, 32'h00000000});
    exp_words.push_back({1'b0, 32'h00000000});
    exp_words.push_back({1'b1, 32'h00000002});
    do_start(15'h0000, 16'd100);
    repeat (80) @(negedge clk);
    check("stall_ctrl", 64'({busy, q_valid, res_valid}), 64'b101);
    check("stall_q_code", 64'(q_code), 64'h40);
    check("stall_head", 64'({res_last, res_data}), 64'h8);
    check("stall_codes_left", 64'(exp_codes.size()), 64'd36);
    @(posedge clk); #1 res_ready = 1'b1;
    wait_done("stall", 300, 1'b1);
    check("stall_blk_cnt", 64'(blk_cnt), 64'd2);
    check_drained("stall");

    // Reset in the middle of issue at index 10.
    hit_n = 1; hit_a = 15'h0105;
    push_codes(15'h0100, 11);
    do_start(15'h0100, 16'd40);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (q_valid === 1'b1 && q_code == 15'h010A) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midrst_reach actual=none required=q_code 010a");
    end
    check("midrst_blk_before", 64'(blk_cnt), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ctrl", 64'({busy, done, q_valid, res_valid, res_last}), 64'd0);
    check("midrst_q_code", 64'(q_code), 64'd0);
    check("midrst_res_data", 64'(res_data), 64'd0);
    check("midrst_blk_cnt", 64'(blk_cnt), 64'd0);
    check_drained("midrst");
    hit_n = 1; hit_a = 15'h0022;
    push_codes(15'h0020, 3);
    exp_words.push_back({1'b1, 32'h00000004});
    do_start(15'h0020, 16'd3);
    wait_done("postrst", 50, 1'b1);
    check("postrst_blk_cnt", 64'(blk_cnt), 64'd1);
    check_drained("postrst");

    // Start while busy must be ignored.
    hit_n = 0;
    push_codes(15'h0040, 6);
    exp_words.push_back({1'b1, 32'h00000000});
    do_start(15'h0040, 16'd6);
    @(posedge clk); #1;
    base_code = 15'h0500; count = 16'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("busystart", 50, 1'b1);
    repeat (10) @(negedge clk);
    check("busystart_idle", 64'({busy, q_valid, res_valid}), 64'd0);
    check_drained("busystart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
